// File: rtl/tree_path_matcher.sv
`default_nettype none
// ============================================================================
// tree_path_matcher: identifier path stack matched against a dependency table
// Revision: 1.0
// ============================================================================
module tree_path_matcher #(
   parameter int NUM_MSG_HIERARCHY = 2,
   parameter int NUM_MSGS          = 2,
   parameter int IDENTIFIER_SIZE   = 5,
   parameter int IW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
   parameter int DW = $clog2(NUM_MSG_HIERARCHY + 1)
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              in_valid,
   output logic                                              in_ready,
   input  logic [1:0]                                        in_op,
   input  logic [IDENTIFIER_SIZE-1:0]                        in_id,
   input  logic [NUM_MSGS*NUM_MSG_HIERARCHY*IDENTIFIER_SIZE-1:0] dep_table,
   output logic                                              out_valid,
   input  logic                                              out_ready,
   output logic                                              out_hit,
   output logic [IW-1:0]                                     out_idx,
   output logic [DW-1:0]                                     out_depth,
   output logic                                              out_err
);

   localparam logic [1:0] C_OP_LOOKUP = 2'b00;
   localparam logic [1:0] C_OP_PUSH   = 2'b01;
   localparam logic [1:0] C_OP_POP    = 2'b10;
   localparam logic [1:0] C_OP_CLEAR  = 2'b11;

   logic [IDENTIFIER_SIZE-1:0] stack_q [NUM_MSG_HIERARCHY];
   logic [IDENTIFIER_SIZE-1:0] stack_d [NUM_MSG_HIERARCHY];
   logic [DW-1:0]              depth_q, depth_d;

   logic          out_valid_q, out_hit_q, out_err_q;
   logic [IW-1:0] out_idx_q;
   logic [DW-1:0] out_depth_q;

   logic                w_accept;
   logic                w_err;
   logic [NUM_MSGS-1:0] w_entry_hit;
   logic                w_any_hit;
   logic [IW-1:0]       w_hit_idx;

   assign in_ready = !out_valid_q || out_ready;
   assign w_accept = in_valid && in_ready;

   assign w_err = ((in_op == C_OP_PUSH) &&
                   ((depth_q == DW'(NUM_MSG_HIERARCHY)) || (in_id == '0))) ||
                  ((in_op == C_OP_POP) && (depth_q == '0));

   // Path as it will stand after the offered op; rejected ops leave it untouched.
   always_comb begin
      stack_d = stack_q;
      depth_d = depth_q;
      if (!w_err) begin
         case (in_op)
            C_OP_PUSH: begin
               for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
                  if (DW'(k) == depth_q) stack_d[k] = in_id;
               end
               depth_d = depth_q + DW'(1);
            end
            C_OP_POP: begin
               for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
                  if (DW'(k) == depth_q - DW'(1)) stack_d[k] = '0;
               end
               depth_d = depth_q - DW'(1);
            end
            C_OP_CLEAR: begin
               for (int k = 0; k < NUM_MSG_HIERARCHY; k++) stack_d[k] = '0;
               depth_d = '0;
            end
            default: ;
         endcase
      end
   end

   for (genvar j = 0; j < NUM_MSGS; j++) begin : g_entry
      logic w_hit;
      always_comb begin
         w_hit = (depth_d != '0);
         for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
            if (DW'(k) < depth_d) begin
               if (dep_table[(j*NUM_MSG_HIERARCHY+k)*IDENTIFIER_SIZE +: IDENTIFIER_SIZE]
                   != stack_d[k]) w_hit = 1'b0;
            end else begin
               if (dep_table[(j*NUM_MSG_HIERARCHY+k)*IDENTIFIER_SIZE +: IDENTIFIER_SIZE]
                   != '0) w_hit = 1'b0;
            end
         end
      end
      assign w_entry_hit[j] = w_hit;
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      w_any_hit = 1'b0;
      w_hit_idx = '0;
      for (int j = NUM_MSGS - 1; j >= 0; j--) begin
         if (w_entry_hit[j]) begin
            w_any_hit = 1'b1;
            w_hit_idx = IW'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_MSG_HIERARCHY; k++) stack_q[k] <= '0;
         depth_q     <= '0;
         out_valid_q <= 1'b0;
         out_hit_q   <= 1'b0;
         out_idx_q   <= '0;
         out_depth_q <= '0;
         out_err_q   <= 1'b0;
      end else if (w_accept) begin
         stack_q     <= stack_d;
         depth_q     <= depth_d;
         out_valid_q <= 1'b1;
         out_hit_q   <= w_any_hit && !w_err;
         out_idx_q   <= w_err ? '0 : w_hit_idx;
         out_depth_q <= depth_d;
         out_err_q   <= w_err;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_hit   = out_hit_q;
   assign out_idx   = out_idx_q;
   assign out_depth = out_depth_q;
   assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_path_matcher.sv
`default_nettype none
// ============================================================================
// tb_tree_path_matcher: scoreboard bench for tree_path_matcher
// Revision: 1.0
// ============================================================================
module tb_tree_path_matcher;

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_PUSH   = 2'b01;
   localparam logic [1:0] OP_POP    = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   typedef struct packed {
      logic       hit;
      logic [0:0] idx;
      logic [1:0] depth;
      logic       err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [4:0]  in_id;
   logic [19:0] dep_table;
   logic        out_valid;
   logic        out_ready;
   logic        out_hit;
   logic [0:0]  out_idx;
   logic [1:0]  out_depth;
   logic        out_err;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   localparam logic [19:0] TABLE_DEFAULT = {5'd4, 5'd1, 5'd0, 5'd1};

   always #5 clk = ~clk;

   tree_path_matcher dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_id     (in_id),
      .dep_table (dep_table),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hit   (out_hit),
      .out_idx   (out_idx),
      .out_depth (out_depth),
      .out_err   (out_err)
   );

   function automatic exp_t mk(input logic h, input logic i, input logic [1:0] d, input logic e);
      exp_t r;
      r.hit = h; r.idx = i; r.depth = d; r.err = e;
      return r;
   endfunction

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   // Monitor: one pop per result handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         exp_t a, e;
         a = mk(out_hit, out_idx, out_depth, out_err);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: got hit=%b idx=%0d depth=%0d err=%b with empty scoreboard",
                     a.hit, a.idx, a.depth, a.err);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               failures++;
               $display("FAIL result: got hit=%b idx=%0d depth=%0d err=%b expected hit=%b idx=%0d depth=%0d err=%b",
                        a.hit, a.idx, a.depth, a.err, e.hit, e.idx, e.depth, e.err);
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [4:0] id, input exp_t e);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_id = id;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #2 out_ready = r;
   endtask

   initial begin
      exp_t held;
      int   n;
      rst_n = 1'b0; in_valid = 1'b0; in_op = OP_LOOKUP; in_id = '0;
      out_ready = 1'b1; dep_table = TABLE_DEFAULT;
      #12;
      check_bit("reset_out_valid", out_valid, 1'b0);
      check_bit("reset_in_ready", in_ready, 1'b1);
      checks++;
      if ({out_hit, out_idx, out_depth, out_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_fields: got %b expected 00000", {out_hit, out_idx, out_depth, out_err});
      end
      @(negedge clk); rst_n = 1'b1;

      // Push/pop walk through the default table
      send(OP_PUSH,   5'd1, mk(1, 0, 2'd1, 0));
      send(OP_PUSH,   5'd4, mk(1, 1, 2'd2, 0));
      send(OP_POP,    5'd0, mk(1, 0, 2'd1, 0));
      send(OP_PUSH,   5'd4, mk(1, 1, 2'd2, 0));
      send(OP_PUSH,   5'd7, mk(0, 0, 2'd2, 1));
      send(OP_LOOKUP, 5'd0, mk(1, 1, 2'd2, 0));
      send(OP_CLEAR,  5'd0, mk(0, 0, 2'd0, 0));
      send(OP_POP,    5'd0, mk(0, 0, 2'd0, 1));
      send(OP_PUSH,   5'd0, mk(0, 0, 2'd0, 1));
      send(OP_PUSH,   5'd2, mk(0, 0, 2'd1, 0));
      send(OP_POP,    5'd0, mk(0, 0, 2'd0, 0));
      send(OP_LOOKUP, 5'd0, mk(0, 0, 2'd0, 0));
      idle(2);

      // Table rewritten while idle; duplicate entries resolve to the lowest index
      dep_table = {5'd0, 5'd2, 5'd0, 5'd2};
      send(OP_PUSH,   5'd2, mk(1, 0, 2'd1, 0));
      idle(1);
      dep_table = {5'd0, 5'd2, 5'd0, 5'd3};
      send(OP_LOOKUP, 5'd0, mk(1, 1, 2'd1, 0));
      idle(1);
      dep_table = TABLE_DEFAULT;
      send(OP_CLEAR,  5'd0, mk(0, 0, 2'd0, 0));
      idle(2);

      // Backpressure: result must hold while out_ready is low
      set_ready(1'b0);
      held = mk(1, 0, 2'd1, 0);
      send(OP_PUSH, 5'd1, held);
      @(negedge clk); in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_bit("stall_out_valid", out_valid, 1'b1);
         check_bit("stall_in_ready", in_ready, 1'b0);
         checks++;
         if ({out_hit, out_idx, out_depth, out_err} !== held) begin
            failures++;
            $display("FAIL stall_hold: got %b expected %b", {out_hit, out_idx, out_depth, out_err}, held);
         end
         @(negedge clk);
      end
      set_ready(1'b1);
      send(OP_PUSH, 5'd4, mk(1, 1, 2'd2, 0));
      #2 out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b0;
      check_bit("pending_out_valid", out_valid, 1'b1);

      // Asynchronous reset with a depth-2 result pending
      #3 rst_n = 1'b0;
      #1;
      check_bit("async_rst_out_valid", out_valid, 1'b0);
      check_bit("async_rst_in_ready", in_ready, 1'b1);
      checks++;
      if (out_depth !== 2'd0) begin
         failures++;
         $display("FAIL async_rst_depth: got %0d expected 0", out_depth);
      end
      sb.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      send(OP_LOOKUP, 5'd0, mk(0, 0, 2'd0, 0));
      idle(1);

      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
